// File: rtl/serial_word_capture.sv
// serial_word_capture: deserializes a 74299-style serial stream into WIDTH-bit words
// and queues them in a first-word-fall-through FIFO drained over valid/ready.
//
// Ports:
//   clk        system clock, rising-edge active
//   clr_n      asynchronous active-low reset
//   shift_en   sample sdata this cycle
//   sdata      serial data bit
//   dir        0: new bit enters LSB (MSB-first), 1: new bit enters MSB (LSB-first)
//   start      word-alignment strobe, discards the partial word
//   word_ready consumer accepts the head word
//   clear_ovf  clears the sticky overflow flag
//   word_out   FIFO head word (0 while empty)
//   word_valid FIFO non-empty
//   fill       words currently held
//   bit_cnt    bits collected in the current partial word
//   overflow   sticky, a completed word was dropped on a full FIFO
module serial_word_capture #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       shift_en,
    input  logic                       sdata,
    input  logic                       dir,
    input  logic                       start,
    input  logic                       word_ready,
    input  logic                       clear_ovf,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic                       overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    logic [WIDTH-1:0] shreg, base, nxt;
    logic [CW-1:0]    cnt_base;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop, full, store;

    // start wipes the partial word before this cycle's bit is applied
    always_comb begin
        base     = start ? '0 : shreg;
        cnt_base = start ? '0 : bit_cnt;
        nxt      = dir ? {sdata, base[WIDTH-1:1]} : {base[WIDTH-2:0], sdata};
        push     = shift_en && (cnt_base == LAST);
        pop      = word_valid && word_ready;
        full     = fill == FULL;
        // a full FIFO still accepts the word when the head leaves in the same cycle
        store    = push && (!full || pop);
    end

    assign word_valid = fill != '0;
    assign word_out   = word_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            shreg   <= shift_en ? nxt : base;
            bit_cnt <= shift_en ? (push ? '0 : cnt_base + CW'(1)) : cnt_base;
        end
    end

    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr] <= nxt;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + {{AW{1'b0}}, store} - {{AW{1'b0}}, pop};
            // a new drop beats a simultaneous clear
            if (push && !store)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_word_capture.sv
// tb_serial_word_capture: directed and randomized checks of serial_word_capture against a queue model.
module tb_serial_word_capture;
    localparam int W = 16;
    localparam int D = 4;

    logic clk = 0, clr_n = 0, shift_en = 0, sdata = 0, dir = 0, start = 0, word_ready = 0, clear_ovf = 0;
    logic [W-1:0] word_out;
    logic word_valid, overflow;
    logic [2:0] fill;
    logic [3:0] bit_cnt;

    int vectors = 0, errors = 0;

    logic [W-1:0] q[$];
    int unsigned m_w, m_n;
    logic m_ovf;

    serial_word_capture #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .clr_n(clr_n), .shift_en(shift_en), .sdata(sdata), .dir(dir),
        .start(start), .word_ready(word_ready), .clear_ovf(clear_ovf),
        .word_out(word_out), .word_valid(word_valid), .fill(fill),
        .bit_cnt(bit_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_w = 0;
        m_n = 0;
        m_ovf = 0;
    endtask

    task automatic step(input logic en, input logic d, input logic dr, input logic st,
                        input logic rdy, input logic co);
        int unsigned bw, bn;
        logic pop, push, dropped;
        shift_en = en; sdata = d; dir = dr; start = st; word_ready = rdy; clear_ovf = co;
        @(posedge clk);
        pop = (q.size() > 0) && rdy;
        bw = st ? 0 : m_w;
        bn = st ? 0 : m_n;
        push = en && (bn == W - 1);
        if (en)
            bw = dr ? ((bw / 2) + (d ? 32768 : 0)) : (((bw * 2) % 65536) + (d ? 1 : 0));
        if (pop)
            void'(q.pop_front());
        dropped = 0;
        if (push) begin
            if (q.size() < D) q.push_back(bw[W-1:0]);
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (co) m_ovf = 0;
        m_w = bw;
        m_n = en ? (push ? 0 : bn + 1) : bn;
        #1;
        shift_en = 0; start = 0; word_ready = 0; clear_ovf = 0;
    endtask

    task automatic send_bits(input logic [W-1:0] val, input int n, input logic lsb_first,
                             input logic dr, input logic rdy_last);
        for (int i = 0; i < n; i++)
            step(1, lsb_first ? val[i] : val[n-1-i], dr, 0, rdy_last && (i == n - 1), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 0;
        @(negedge clk);
        clr_n = 1;
        model_clear();
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr_n = 0;
        for (int i = 0; i < 4; i++) begin
            shift_en = 1; sdata = i[0]; dir = i[1]; start = i[0]; word_ready = 1; clear_ovf = 0;
            @(negedge clk);
            vectors++;
            if ({word_out, word_valid, fill, bit_cnt, overflow} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got out=%h v=%b fill=%0d cnt=%0d ovf=%b want all 0",
                         word_out, word_valid, fill, bit_cnt, overflow);
            end
        end
        shift_en = 0; start = 0; word_ready = 0; sdata = 0; dir = 0;
        clr_n = 1;
        model_clear();
        send_bits(16'hA5C3, W, 0, 0, 0);
        vectors++;
        if (word_valid !== 1 || word_out !== 16'hA5C3 || fill !== 1 || bit_cnt !== 0) begin
            errors++;
            $display("FAIL first_word got v=%b out=%h fill=%0d cnt=%0d want v=1 out=a5c3 fill=1 cnt=0",
                     word_valid, word_out, fill, bit_cnt);
        end
    endtask

    task automatic test_direction();
        do_reset();
        send_bits(16'hA5C3, W, 1, 1, 0);
        vectors++;
        if (word_out !== 16'hA5C3) begin
            errors++;
            $display("FAIL dir_right got %h want a5c3", word_out);
        end
        do_reset();
        send_bits(16'hA5C3, W, 1, 0, 0);
        vectors++;
        if (word_out !== 16'hC3A5) begin
            errors++;
            $display("FAIL dir_left_reversed got %h want c3a5", word_out);
        end
    endtask

    task automatic test_realign();
        do_reset();
        send_bits(16'h001F, 5, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        vectors++;
        if (bit_cnt !== 1 || fill !== 0) begin
            errors++;
            $display("FAIL realign_start got cnt=%0d fill=%0d want cnt=1 fill=0", bit_cnt, fill);
        end
        send_bits(16'h0001, 15, 0, 0, 0);
        vectors++;
        if (word_out !== 16'h8001 || bit_cnt !== 0 || fill !== 1) begin
            errors++;
            $display("FAIL realign_word got out=%h cnt=%0d fill=%0d want 8001 0 1", word_out, bit_cnt, fill);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++)
            send_bits(W'(k), W, 0, 0, 0);
        vectors++;
        if (fill !== 4 || overflow !== 1) begin
            errors++;
            $display("FAIL overflow_set got fill=%0d ovf=%b want 4 1", fill, overflow);
        end
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (word_out !== W'(k) || word_valid !== 1) begin
                errors++;
                $display("FAIL overflow_drain got %h v=%b want %h v=1", word_out, word_valid, W'(k));
            end
            step(0, 0, 0, 0, 1, 0);
        end
        vectors++;
        if (fill !== 0 || word_valid !== 0 || overflow !== 1) begin
            errors++;
            $display("FAIL overflow_empty got fill=%0d v=%b ovf=%b want 0 0 1", fill, word_valid, overflow);
        end
        step(0, 0, 0, 0, 0, 1);
        vectors++;
        if (overflow !== 0) begin
            errors++;
            $display("FAIL overflow_clear got %b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int k = 1; k <= 4; k++)
            send_bits(W'(k), W, 0, 0, 0);
        send_bits(16'h0005, W, 0, 0, 1);
        vectors++;
        if (fill !== 4 || overflow !== 0) begin
            errors++;
            $display("FAIL full_push_pop got fill=%0d ovf=%b want 4 0", fill, overflow);
        end
        for (int k = 2; k <= 5; k++) begin
            vectors++;
            if (word_out !== W'(k)) begin
                errors++;
                $display("FAIL full_drain got %h want %h", word_out, W'(k));
            end
            step(0, 0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_bits(16'h1234, W, 0, 0, 0);
        send_bits(16'h5678, W, 0, 0, 0);
        send_bits(16'h01FF, 9, 0, 0, 0);
        vectors++;
        if (fill !== 2 || bit_cnt !== 9) begin
            errors++;
            $display("FAIL mid_setup got fill=%0d cnt=%0d want 2 9", fill, bit_cnt);
        end
        #2 clr_n = 0;
        #1;
        vectors++;
        if (fill !== 0 || word_valid !== 0 || bit_cnt !== 0 || word_out !== 0) begin
            errors++;
            $display("FAIL mid_reset got fill=%0d v=%b cnt=%0d out=%h want 0 0 0 0",
                     fill, word_valid, bit_cnt, word_out);
        end
        @(negedge clk);
        clr_n = 1;
        model_clear();
        for (int i = 0; i < W; i++)
            step(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        vectors++;
        if (fill !== 1 || word_valid !== 1 || bit_cnt !== 0 || word_out !== q[0]) begin
            errors++;
            $display("FAIL mid_one_word got fill=%0d v=%b cnt=%0d out=%h want 1 1 0 %h",
                     fill, word_valid, bit_cnt, word_out, q[0]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_out;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            exp_out = q.size() > 0 ? q[0] : '0;
            vectors++;
            if (word_out !== exp_out) begin
                errors++;
                $display("FAIL rand_word_out cyc %0d got %h want %h", i, word_out, exp_out);
            end
            vectors++;
            if (word_valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL rand_valid cyc %0d got %b want %b", i, word_valid, q.size() > 0);
            end
            vectors++;
            if (fill !== 3'(q.size())) begin
                errors++;
                $display("FAIL rand_fill cyc %0d got %0d want %0d", i, fill, q.size());
            end
            vectors++;
            if (bit_cnt !== 4'(m_n)) begin
                errors++;
                $display("FAIL rand_bit_cnt cyc %0d got %0d want %0d", i, bit_cnt, m_n);
            end
            vectors++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_overflow cyc %0d got %b want %b", i, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direction();
        test_realign();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/serial_word_capture.md
# serial_word_capture

Deserializing receiver for bit streams shifted out of 74299-style universal shift-register chains (QS0/QS7 taps) in the Star Wars arcade core. It samples one serial bit per enabled clock and assembles WIDTH-bit words in either shift direction. Completed words go into a small first-word-fall-through FIFO, which a downstream consumer drains over a valid/ready handshake. Sits between the shift-register datapath and any parallel consumer, such as the CPU read port or the math-box result latch.

## Interface

Parameters:
- WIDTH, 16, word length in bits (≥2)
- DEPTH, 4, FIFO depth in words; power of two, ≥2

Ports:
- clk  in  1  single system clock; all state changes on rising edge
- clr_n  in  1  asynchronous active-low reset
- shift_en  in  1  sample sdata this cycle
- sdata  in  1  serial data bit
- dir  in  1  0 = shift left, new bit enters LSB (MSB-first stream); 1 = shift right, new bit enters MSB (LSB-first stream)
- start  in  1  word-alignment strobe; discards the partial word
- word_ready  in  1  consumer accepts head word
- clear_ovf  in  1  clears sticky overflow
- word_out  out  WIDTH  FIFO head word
- word_valid  out  1  FIFO non-empty
- fill  out  $clog2(DEPTH)+1  words currently held
- bit_cnt  out  $clog2(WIDTH)  bits collected in the current partial word
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full

## Operation

- Reset (clr_n low, asynchronous):
  - shreg, bit_cnt, FIFO pointers, fill, overflow all go to 0.
  - word_valid = 0; word_out = 0.
- Shift step, when shift_en = 1:
  - dir = 0: next = {shreg[WIDTH-2:0], sdata}.
  - dir = 1: next = {sdata, shreg[WIDTH-1:1]}.
  - dir is sampled per bit; a mid-word change is legal and follows the formulas above.
- Word completion: a shift with bit_cnt = WIDTH-1 pushes next into the FIFO and sets bit_cnt to 0. Otherwise bit_cnt increments. shreg always takes next.
- start = 1: bit_cnt and shreg are cleared before this cycle's shift is applied.
  - With shift_en = 1 in the same cycle, the bit becomes bit 0 of a new word and bit_cnt = 1.
  - With shift_en = 0, bit_cnt = 0.
  - start never pushes a word.
- FIFO behaviour:
  - Pop occurs when word_valid & word_ready.
  - Push when not full: stored at the tail.
  - Push when full and no pop in the same cycle: the word is dropped and overflow is set.
  - Push and pop in the same cycle with fill = DEPTH: both occur, no overflow, fill unchanged.
  - Push and pop with fill = 0: the word is stored and fill becomes 1. Nothing is popped, since word_valid was 0.
  - Pointers wrap modulo DEPTH.
- overflow stays set until clear_ovf = 1. If clear_ovf coincides with a new overflow event, set wins.
- word_ready while word_valid = 0 is ignored.

## Timing

- Latency: the last bit is sampled at edge N. word_valid and word_out reflect that word after edge N, provided the FIFO was empty.
- word_out and word_valid are registered-state outputs with no combinational path from any input.
- Throughput: one bit per clock. When WIDTH ≥ 2, at most one push and one pop per cycle.
- fill and bit_cnt update on the same edge as the events that change them.
- Reset asserted mid-word or mid-drain discards everything; the first post-reset shift is bit 0.

## Test plan

- Reset: hold clr_n low, toggle inputs -> all outputs 0. Release, shift WIDTH=16 bits of 0xA5C3 MSB-first with dir = 0 and word_ready = 0 -> after the 16th edge word_valid = 1, word_out = 0xA5C3, fill = 1, bit_cnt = 0.
- Direction: shift 0xA5C3 LSB-first with dir = 1 -> word_out = 0xA5C3. Shift the same bit sequence with dir = 0 -> word_out = 0xC3A5, the bit-reversal.
- Realign: shift 5 bits, assert start with shift_en = 1 and sdata = 1, then 15 more bits of 0x0001 pattern (MSB-first, dir = 0) -> word_out = 0x8001, bit_cnt = 0, no extra word pushed.
- Overflow: with word_ready = 0, push 5 words (0x0001 through 0x0005) at DEPTH = 4 -> fill = 4, overflow = 1, FIFO drains 0x0001 through 0x0004. Then pulse clear_ovf -> overflow = 0.
- Full push+pop: at fill = 4, hold word_ready = 1 on the cycle the 5th word completes -> no overflow, fill stays 4, drain order 2,3,4,5.
- Reset mid-operation: assert clr_n low at bit 9 with fill = 2 -> fill = 0, word_valid = 0, bit_cnt = 0. The next 16 shifts produce exactly one word.
